// File: rtl/pipelined_ripple_carry_add_if.sv
// Operand/result handshake bundle for pipelined_ripple_carry_add.
// PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN adds the z/ov status flags.
interface pipelined_ripple_carry_add_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         co;
`ifdef PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN
  logic         z;
  logic         ov;
`endif

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, c, co
`ifdef PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN
    , input z, ov
`endif
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, c, co
`ifdef PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN
    , output z, ov
`endif
  );
endinterface

// File: rtl/pipelined_ripple_carry_add.sv
// N-bit add/subtract split into S ripple chunks, one chunk per pipeline stage,
// with valid/ready flow control. Optional z/ov flags: PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN.
module pipelined_ripple_carry_add #(
  parameter int unsigned N = 32,
  parameter int unsigned S = 4
) (
  input logic                          clk,
  input logic                          rst,
  pipelined_ripple_carry_add_if.slave  bus
);
  localparam int unsigned W = N / S;

  generate
    if (N < 2 || S < 1 || S > N || (N % S) != 0) begin : g_bad_cfg
      $error("pipelined_ripple_carry_add: illegal N/S combination");
    end
  endgenerate

  logic [S-1:0] valid_q, valid_d;
  logic [S-1:0] carry_q, carry_d;
  logic [N-1:0] a_q   [S];
  logic [N-1:0] a_d   [S];
  logic [N-1:0] b_q   [S];
  logic [N-1:0] b_d   [S];
  logic [N-1:0] sum_q [S];
  logic [N-1:0] sum_d [S];

  logic         advance;
  logic [S-1:0] in_v, in_cy, res_cy;
  logic [N-1:0] in_a    [S];
  logic [N-1:0] in_b    [S];
  logic [N-1:0] in_sum  [S];
  logic [N-1:0] res_sum [S];
  logic [W:0]   chunk;

  // Stage k sees either the bus (k=0) or stage k-1's registers; b is pre-inverted for subtract.
  always_comb begin
    advance = !valid_q[S-1] || bus.out_ready;
    chunk   = '0;
    in_v    = '0;
    in_cy   = '0;
    res_cy  = '0;
    valid_d = '0;
    carry_d = '0;
    for (int unsigned k = 0; k < S; k++) begin
      in_a[k]    = '0;
      in_b[k]    = '0;
      in_sum[k]  = '0;
      res_sum[k] = '0;
      a_d[k]     = '0;
      b_d[k]     = '0;
      sum_d[k]   = '0;
    end

    in_v[0]   = bus.in_valid;
    in_cy[0]  = bus.ci ^ bus.sub;
    in_a[0]   = bus.a;
    in_b[0]   = bus.sub ? ~bus.b : bus.b;
    in_sum[0] = '0;
    for (int unsigned k = 1; k < S; k++) begin
      in_v[k]   = valid_q[k-1];
      in_cy[k]  = carry_q[k-1];
      in_a[k]   = a_q[k-1];
      in_b[k]   = b_q[k-1];
      in_sum[k] = sum_q[k-1];
    end

    for (int unsigned k = 0; k < S; k++) begin
      chunk = {1'b0, in_a[k][k*W +: W]} + {1'b0, in_b[k][k*W +: W]} + {{W{1'b0}}, in_cy[k]};
      res_sum[k]            = in_sum[k];
      res_sum[k][k*W +: W]  = chunk[W-1:0];
      res_cy[k]             = chunk[W];

      valid_d[k] = advance ? in_v[k]    : valid_q[k];
      carry_d[k] = advance ? res_cy[k]  : carry_q[k];
      a_d[k]     = advance ? in_a[k]    : a_q[k];
      b_d[k]     = advance ? in_b[k]    : b_q[k];
      sum_d[k]   = advance ? res_sum[k] : sum_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int unsigned k = 0; k < S; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int unsigned k = 0; k < S; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[S-1];
  assign bus.c         = sum_q[S-1];
  assign bus.co        = carry_q[S-1];

`ifdef PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN
  logic z_q, z_d, ov_q, ov_d;

  // Sign-overflow via operand/result sign bits equals carry-in(N-1) ^ carry-out(N-1).
  always_comb begin
    z_d  = advance ? (res_sum[S-1] == '0) : z_q;
    ov_d = advance ? ((in_a[S-1][N-1] == in_b[S-1][N-1]) &&
                      (res_sum[S-1][N-1] != in_a[S-1][N-1])) : ov_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q  <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      z_q  <= z_d;
      ov_q <= ov_d;
    end
  end

  assign bus.z  = z_q;
  assign bus.ov = ov_q;
`endif
endmodule

// File: tb/tb_pipelined_ripple_carry_add.sv
// Directed bench for pipelined_ripple_carry_add: vector table plus stream, stall
// and reset sequences. z/ov checked when PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN is defined.
module tb_pipelined_ripple_carry_add;
  localparam int unsigned N = 32;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_ripple_carry_add_if #(.N(N)) bus ();

  pipelined_ripple_carry_add #(.N(N), .S(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] c;
    logic        co;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs [10];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned lat;
    int unsigned idx;
    int unsigned nxt;
    int unsigned t;

    //          a             b             ci    sub   c             co    z     ov
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h00000100, 32'h00000001, 1'b0, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_c", 64'(bus.c), 64'd0);
    chk("reset_co", 64'(bus.co), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Single operations: latency and arithmetic per table entry.
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.a   = vecs[i].a;
      bus.b   = vecs[i].b;
      bus.ci  = vecs[i].ci;
      bus.sub = vecs[i].sub;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      lat = 1;
      while (!bus.out_valid && lat < 4 * S + 8) begin
        tick();
        #1;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
      chk($sformatf("vec%0d_c", i), 64'(bus.c), 64'(vecs[i].c));
      chk($sformatf("vec%0d_co", i), 64'(bus.co), 64'(vecs[i].co));
`ifdef PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN
      chk($sformatf("vec%0d_z", i), 64'(bus.z), 64'(vecs[i].z));
      chk($sformatf("vec%0d_ov", i), 64'(bus.ov), 64'(vecs[i].ov));
`endif
    end

    // Eight back-to-back operations at full throughput.
    idx = 0;
    t = 0;
    bus.ci  = 1'b0;
    bus.sub = 1'b0;
    while (idx < 8 && t < 8 + 4 * S + 8) begin
      tick();
      if (t < 8) begin
        bus.in_valid = 1'b1;
        bus.a = 32'(t);
        bus.b = 32'(t * 32'h10);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (t < 8) chk($sformatf("stream_in_ready_t%0d", t), 64'(bus.in_ready), 64'd1);
      if (bus.out_valid) begin
        chk($sformatf("stream_c_%0d", idx), 64'(bus.c), 64'(idx * 32'h11));
        chk($sformatf("stream_co_%0d", idx), 64'(bus.co), 64'd0);
        chk($sformatf("stream_slot_%0d", idx), 64'(t), 64'(idx + S));
        idx++;
      end
      t++;
    end
    chk("stream_count", 64'(idx), 64'd8);

    // Fill, then backpressure for three cycles; ops 1..5 must emerge once, in order.
    nxt = 1;
    idx = 1;
    t = 0;
    while (idx <= 5 && t < 60) begin
      tick();
      bus.out_ready = !(t >= S && t < S + 3);
      if (nxt <= 5) begin
        bus.in_valid = 1'b1;
        bus.a = 32'(nxt);
        bus.b = 32'(nxt) << 8;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (!bus.out_ready) begin
        chk($sformatf("stall_in_ready_t%0d", t), 64'(bus.in_ready), 64'd0);
        chk($sformatf("stall_out_valid_t%0d", t), 64'(bus.out_valid), 64'd1);
        chk($sformatf("stall_c_t%0d", t), 64'(bus.c), 64'(idx * 32'h101));
        chk($sformatf("stall_co_t%0d", t), 64'(bus.co), 64'd0);
      end
      if (bus.in_valid && bus.in_ready) nxt++;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("drain_c_%0d", idx), 64'(bus.c), 64'(idx * 32'h101));
        idx++;
      end
      t++;
    end
    chk("drain_count", 64'(idx), 64'd6);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < int'(S) + 2; i++) begin
      tick();
      #1;
      chk($sformatf("no_duplicate_%0d", i), 64'(bus.out_valid), 64'd0);
    end

    // Reset with three operations in flight; rst also overrides a pending in_valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.a = 32'h1000 + 32'(i);
      bus.b = 32'h1;
    end
    tick();
    rst = 1'b1;
    bus.a = 32'h55;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_c", 64'(bus.c), 64'd0);
    chk("rst_co", 64'(bus.co), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      chk($sformatf("rst_no_stale_%0d", i), 64'(bus.out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pipelined_ripple_carry_add.md
Name: pipelined_ripple_carry_add

Overview:
Parametrised, pipelined successor to the structural ripple-carry adder. It splits an N-bit add/subtract into S equal chunks, one ripple-carry chunk per pipeline stage, and registers the carry between stages. A valid/ready handshake on input and output gives full throughput (one operation per cycle) with backpressure. It is used wherever wide datapaths must close timing that a single N-bit ripple chain cannot.

Parameters:
N, 32, datapath width in bits; N >= 2.
S, 4, pipeline stages and chunk count; 1 <= S <= N and N % S == 0 (elaboration-time error otherwise). Chunk width W = N/S.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  operand set a/b/ci/sub is valid.
in_ready  output  1  block can accept an operand set this cycle.
a  input  N  operand A.
b  input  N  operand B.
ci  input  1  carry-in (add) or borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  c/co hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
c  output  N  result.
co  output  1  carry-out (add); inverted borrow (sub), so co=1 means no borrow.

Behaviour:
- Reset, held through the edge: every stage valid bit clears, out_valid=0, c=0, co=0. in_ready=1 in the first cycle after reset is released. Any in-flight operations are discarded; none emerges later.
- Arithmetic: {co,c} = a + (sub ? ~b : b) + (ci ^ sub), computed modulo 2^(N+1).
  - Subtract therefore returns a - b - ci.
  - Width rule: every chunk is exactly W bits wide; the carry out of a chunk feeds the next chunk only.
- Pipeline:
  - Stage k (k = 0..S-1) adds chunk k, bits [k*W +: W], using the carry registered by stage k-1. Stage 0 uses ci^sub.
  - Upper operand chunks not yet consumed, and lower result chunks already computed, travel alongside in the stage registers.
  - The final stage register drives c, co and out_valid directly (registered outputs).
- Global stall: advance = !out_valid || out_ready. in_ready = advance, which is combinational from out_ready and out_valid.
  - When advance=1, every stage register loads from its predecessor. Stage 0 loads its valid bit from in_valid.
  - When advance=0, all stages hold, including their valid bits. c/co/out_valid remain stable.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: exactly S cycles from the input-transfer edge to out_valid=1 when there is no stall. Each stall cycle adds one cycle.
- Throughput: one operation per cycle with out_ready held high. Results emerge strictly in input order, with no loss and no duplication.
- Bubbles: in_valid=0 on an advancing cycle inserts a bubble. A stage with valid=0 still clocks its data, but out_valid stays 0 for that slot.
- Simultaneous events: an output transfer and an input transfer may occur in the same cycle; the pipeline advances normally. rst overrides everything, including in_valid and out_ready.
- Stall stability: while out_valid=1 and out_ready=0, c and co must not change.
- Wrap-around: overflow beyond N+1 bits wraps silently. S=1 degenerates to a single-stage registered N-bit ripple adder with latency 1.

Optional Feature:
Macro PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN.
- When defined, two extra registered outputs exist, aligned with c (same latency, same stall and reset behaviour, reset value 0):
  - z: 1 when c == 0.
  - ov: signed two's-complement overflow, i.e. the carry into bit N-1 XOR the carry out of bit N-1, evaluated on the effective (possibly inverted) b.
- Both flags are computed in the final stage.
- When undefined, the z and ov ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. N=32, S=4, a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0, out_ready=1 -> out_valid rises 4 cycles after acceptance with c=0x00000000, co=1. This exercises carry propagation through all chunk boundaries.
2. a=5, b=7, ci=0, sub=1 -> c=0xFFFFFFFE, co=0. Repeat with a=7, b=5, ci=1, sub=1 -> c=0x00000001, co=1.
3. Eight back-to-back operations a=i, b=0x10*i (i=0..7), out_ready=1 -> eight consecutive out_valid cycles starting 4 cycles after the first acceptance. Results are c=0x11*i in order, and in_ready stays 1 throughout.
4. Fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0 and c/co/out_valid stable for those cycles. After release, every result appears exactly once, in order.
5. Assert rst for 1 cycle with 3 operations in flight -> out_valid=0, c=0, co=0 after the edge. No stale result appears over the next 8 cycles, and in_ready=1 after release.
6. With PIPELINED_RIPPLE_CARRY_ADD_STATUS_EN defined:
   - a=0x7FFFFFFF, b=1 -> ov=1, z=0.
   - a=0xFFFFFFFF, b=1 -> z=1, ov=0, co=1.
   - With S=1 and S=32, test 1 passes at latencies of 1 and 32 respectively.
